// File: rtl/tdm_pkg.sv
// ============================================================================
// Module   : tdm_pkg
// Purpose  : Shared constants and state type for the 8-channel TDM transmitter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } tdm_state_t;

endpackage

`default_nettype wire

// File: rtl/tdm_next_ch.sv
// ============================================================================
// Module   : tdm_next_ch
// Purpose  : Picks the lowest set mask bit, either from channel 0 or strictly
//            above the current index; flags whether any such channel exists.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_next_ch
  import tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  idx_i,
  input  logic              from_start_i,
  output logic [SEL_W-1:0]  nxt_o,
  output logic              found_o
);

  // Descending scan so the lowest qualifying channel is the one that sticks.
  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (from_start_i || (SEL_W'(i) > idx_i))) begin
        nxt_o   = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdm_mux8.sv
// ============================================================================
// Module   : tdm_mux8
// Purpose  : Eight-channel TDM transmitter; snapshots channel bits per frame and
//            serialises them on 'a' with slot select {p,q,r}.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_mux8
  import tdm_pkg::*;
#(
  parameter int DWELL         = 1,
  parameter bit SKIP_DISABLED = 1'b1
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_in,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              a,
  output logic              p,
  output logic              q,
  output logic              r,
  output logic              frame_start,
  output logic              busy
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  tdm_state_t        state_q, state_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [7:0]        dwell_q, dwell_d;
  logic              a_q, a_d;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] w_start_mask;
  logic [NUM_CH-1:0] w_scan_mask;
  logic [SEL_W-1:0]  w_first_idx;
  logic              w_first_found;
  logic [SEL_W-1:0]  w_adv_idx;
  logic              w_adv_found;
  logic              w_start;
  logic              w_slot_end;
  logic              w_new_frame;

  // With skipping off every channel owns a slot; only 'a' honours the mask.
  assign w_start_mask = SKIP_DISABLED ? ch_mask : '1;
  assign w_scan_mask  = SKIP_DISABLED ? mask_q  : '1;

  tdm_next_ch u_first (
    .mask_i       (w_start_mask),
    .idx_i        ('0),
    .from_start_i (1'b1),
    .nxt_o        (w_first_idx),
    .found_o      (w_first_found)
  );

  tdm_next_ch u_adv (
    .mask_i       (w_scan_mask),
    .idx_i        (idx_q),
    .from_start_i (1'b0),
    .nxt_o        (w_adv_idx),
    .found_o      (w_adv_found)
  );

  assign w_start    = en & w_first_found;
  assign w_slot_end = (dwell_q == DWELL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      dwell_q <= '0;
      a_q     <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      a_q     <= a_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    w_new_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_start) begin
          state_d     = SCAN;
          w_new_frame = 1'b1;
        end
      end
      SCAN: begin
        if (!w_slot_end) begin
          dwell_d = dwell_q + 8'd1;
        end else if (w_adv_found) begin
          idx_d   = w_adv_idx;
          dwell_d = '0;
        end else if (w_start) begin
          w_new_frame = 1'b1;
        end else begin
          state_d = IDLE;
          dwell_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame snapshot: later input changes stay invisible until the next frame.
    if (w_new_frame) begin
      data_d  = ch_in;
      mask_d  = ch_mask;
      idx_d   = w_first_idx;
      dwell_d = '0;
    end
  end

  always_comb begin
    a_d    = (state_d == SCAN) ? (data_d[idx_d] & mask_d[idx_d]) : 1'b0;
    fs_d   = w_new_frame;
    busy_d = (state_d == SCAN);
  end

  assign a           = a_q;
  assign p           = idx_q[2];
  assign q           = idx_q[1];
  assign r           = idx_q[0];
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_mux8.sv
// ============================================================================
// Module   : tb_tdm_mux8
// Purpose  : Scoreboard bench for tdm_mux8 (DWELL=3 with skipping, DWELL=1
//            without skipping) against a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_mux8;

  typedef struct packed {
    logic       busy;
    logic [2:0] sel;
    logic       a;
    logic       fs;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [7:0] ch_in = 8'h00;
  logic [7:0] ch_mask = 8'h00;

  logic a_0, p_0, q_0, r_0, fs_0, busy_0;
  logic a_1, p_1, q_1, r_1, fs_1, busy_1;

  obs_t       exp_q0[$];
  obs_t       exp_q1[$];
  int         rem[2];
  logic [2:0] last_sel[2];
  int         n_tests = 0;
  int         n_fail = 0;
  bit         sb_on = 1'b0;

  always #5 clk = ~clk;

  tdm_mux8 #(.DWELL(3), .SKIP_DISABLED(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_in(ch_in), .ch_mask(ch_mask),
    .a(a_0), .p(p_0), .q(q_0), .r(r_0), .frame_start(fs_0), .busy(busy_0)
  );

  tdm_mux8 #(.DWELL(1), .SKIP_DISABLED(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_in(ch_in), .ch_mask(ch_mask),
    .a(a_1), .p(p_1), .q(q_1), .r(r_1), .frame_start(fs_1), .busy(busy_1)
  );

  function automatic int dwell_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic bit skip_of(input int k);
    return (k == 0);
  endfunction

  task automatic push(input int k, input obs_t e);
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Reference: at a frame boundary, list every slot of the whole frame.
  task automatic model_edge(input int k);
    logic [7:0] eff;
    obs_t       e;
    int         nslot;
    eff = skip_of(k) ? ch_mask : 8'hFF;
    if (rem[k] > 1) begin
      rem[k]--;
    end else if (en && (eff != 8'h00)) begin
      nslot = 0;
      for (int ch = 0; ch < 8; ch++) begin
        if (eff[ch]) begin
          for (int d = 0; d < dwell_of(k); d++) begin
            e.busy = 1'b1;
            e.sel  = 3'(ch);
            e.a    = ch_in[ch] & ch_mask[ch];
            e.fs   = (nslot == 0) && (d == 0);
            push(k, e);
          end
          nslot++;
          last_sel[k] = 3'(ch);
        end
      end
      rem[k] = nslot * dwell_of(k);
    end else begin
      rem[k] = 0;
      e.busy = 1'b0;
      e.sel  = last_sel[k];
      e.a    = 1'b0;
      e.fs   = 1'b0;
      push(k, e);
    end
  endtask

  task automatic apply(input logic e_i, input logic [7:0] d_i, input logic [7:0] m_i);
    en      = e_i;
    ch_in   = d_i;
    ch_mask = m_i;
    model_edge(0);
    model_edge(1);
    sb_on = 1'b1;
  endtask

  task automatic step(input logic e_i, input logic [7:0] d_i, input logic [7:0] m_i);
    @(negedge clk);
    apply(e_i, d_i, m_i);
  endtask

  task automatic check(input int k, input obs_t got);
    obs_t exp;
    n_tests++;
    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
      n_fail++;
      $display("FAIL sb_underflow dut%0d t=%0t got=%b", k, $time, got);
      return;
    end
    if (k == 0) exp = exp_q0.pop_front();
    else        exp = exp_q1.pop_front();
    if (got !== exp) begin
      n_fail++;
      $display("FAIL slot dut%0d t=%0t got busy=%b sel=%0d a=%b fs=%b, expected busy=%b sel=%0d a=%b fs=%b",
               k, $time, got.busy, got.sel, got.a, got.fs, exp.busy, exp.sel, exp.a, exp.fs);
    end
  endtask

  task automatic check_rst(input int k, input obs_t got);
    n_tests++;
    if (got !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs dut%0d t=%0t got=%b expected=000000", k, $time, got);
    end
  endtask

  task automatic reset_model();
    exp_q0.delete();
    exp_q1.delete();
    rem[0] = 0;
    rem[1] = 0;
    last_sel[0] = 3'd0;
    last_sel[1] = 3'd0;
    sb_on = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_on) begin
        check(0, {busy_0, p_0, q_0, r_0, a_0, fs_0});
        check(1, {busy_1, p_1, q_1, r_1, a_1, fs_1});
      end
    end
  end

  initial begin
    reset_model();
    #1 rst_n = 1'b0;
    #2;
    check_rst(0, {busy_0, p_0, q_0, r_0, a_0, fs_0});
    check_rst(1, {busy_1, p_1, q_1, r_1, a_1, fs_1});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 8'h00, 8'h00);

    // Full mask, single-cycle en pulse; inputs churn mid-frame.
    step(1'b1, 8'b1010_0110, 8'hFF);
    repeat (30) step(1'b0, 8'($urandom), 8'($urandom));

    // Sparse mask 0,2,7.
    step(1'b1, 8'hFF, 8'b1000_0101);
    repeat (30) step(1'b0, 8'h00, 8'h00);

    // Back-to-back frames with en held, data changing mid-frame.
    repeat (4) step(1'b1, 8'h01, 8'h03);
    repeat (4) step(1'b1, 8'h02, 8'h03);
    repeat (16) step(1'b1, 8'($urandom), 8'h03);
    repeat (10) step(1'b0, 8'h00, 8'h03);

    // en dropped a few slots into a full-mask frame.
    repeat (4) step(1'b1, 8'hA5, 8'hFF);
    repeat (30) step(1'b0, 8'h5A, 8'hFF);

    // All-zero mask with en high.
    repeat (12) step(1'b1, 8'hFF, 8'h00);
    repeat (4) step(1'b0, 8'h00, 8'h00);

    // Asynchronous reset mid-frame, then a fresh frame.
    repeat (6) step(1'b1, 8'hFF, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    check_rst(0, {busy_0, p_0, q_0, r_0, a_0, fs_0});
    check_rst(1, {busy_1, p_1, q_1, r_1, a_1, fs_1});
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 8'h3C, 8'hFF);
    repeat (20) step(1'b1, 8'($urandom), 8'hFF);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0),
           8'($urandom),
           ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
    end
    repeat (30) step(1'b0, 8'h00, 8'h00);

    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tdm_mux8.md
# tdm_mux8

Eight-channel time-division multiplexer: the transmit end of the team's 1-to-8 demultiplexer link. Snapshots eight parallel channel bits once per frame and serialises them onto one data line `a`, driving the 3-bit slot select `{p,q,r}` alongside so a downstream 1-to-8 demux routes each bit to output `f{p,q,r}`. Sits between parallel status/control sources and the shared serial link.

## Interface
Parameters:
- `DWELL`, default 1: cycles each slot is held on the link (1..255).
- `SKIP_DISABLED`, default 1: 1 = masked channels get no slot; 0 = masked channels keep their slot with `a`=0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  level request: start frames / keep framing.
- `ch_in`  in  8  parallel channel data, bit i = channel i.
- `ch_mask`  in  8  channel enable, bit i = 1 means channel i is transmitted.
- `a`  out  1  serial data for the current slot.
- `p`  out  1  select MSB (channel index bit 2).
- `q`  out  1  select bit 1.
- `r`  out  1  select LSB (channel index bit 0).
- `frame_start`  out  1  high during the first cycle of each frame's first slot.
- `busy`  out  1  high while in SCAN.

## Operation
- States: IDLE, SCAN.
- IDLE: `a`=0, `busy`=0, `frame_start`=0; `{p,q,r}` hold last value (3'b000 after reset).
- IDLE -> SCAN on a clock edge with `en`=1 and an effective mask ≠ 0 (effective mask = `ch_mask` if `SKIP_DISABLED`=1, else 8'hFF). Same edge captures `ch_in` into `data_q` and `ch_mask` into `mask_q` (frame snapshot). Mid-frame changes to `ch_in`/`ch_mask` have no effect.
- `en`=1 with an all-zero mask (`SKIP_DISABLED`=1): remain IDLE; no frame.
- SCAN: slots visit channels in ascending index order. `{p,q,r}` = channel index; `a` = `data_q[idx] & mask_q[idx]`.
- Each slot lasts exactly `DWELL` cycles (dwell counter counts 0..DWELL-1).
- Slot advance: to next higher channel whose snapshot-mask bit is set (`SKIP_DISABLED`=1) or to idx+1 (`SKIP_DISABLED`=0).
- End of frame (last slot's final cycle): if `en`=1 → new snapshot on that edge, begin next frame without a gap cycle, `frame_start` pulses again; if `en`=0 → IDLE.
- `en` falling mid-frame does not abort: the frame completes.
- Index arithmetic is 3-bit; no wrap within a frame (channel 7 always ends the frame, or the highest enabled channel when skipping).

## Timing
- Reset (asynchronous, immediate): state IDLE, `a`=0, `p`=`q`=`r`=0, `frame_start`=0, `busy`=0, `data_q`=`mask_q`=0, dwell counter 0. Reset mid-frame abandons the frame; after release, framing resumes only via a new IDLE->SCAN transition.
- All outputs registered; no combinational path from inputs to outputs.
- Latency: `en` sampled high at edge N → first slot visible after edge N, `frame_start`=1 and `busy`=1 in that same cycle.
- Frame length = (number of slots) × `DWELL` cycles; back-to-back frames have zero idle cycles.
- `busy` drops in the cycle after the last slot's final cycle when returning to IDLE.

## Structure
- Package `tdm_pkg`: `NUM_CH`=8, `SEL_W`=3, state enum `tdm_state_t` {IDLE, SCAN}.
- Sub-module `tdm_next_ch`: combinational; inputs 8-bit mask and current 3-bit index (plus a "from start" flag); outputs next set index and `found`. Used for both first-slot and slot-advance selection.
- Top holds FSM, dwell counter, snapshot registers, output registers.

## Test plan
- Full mask, `DWELL`=1: `ch_in`=8'b1010_0110, `ch_mask`=8'hFF, pulse `en` one cycle → 8 slots, `{p,q,r}` 0..7, `a` = 0,1,1,0,0,1,0,1; `frame_start` only on slot 0; IDLE afterwards.
- Skipping: `ch_mask`=8'b1000_0101, `ch_in`=8'hFF, `SKIP_DISABLED`=1 → 3 slots, selects 0,2,7, `a`=1 each; `SKIP_DISABLED`=0 → 8 slots, `a`=1 only at 0,2,7.
- Dwell and back-to-back: `DWELL`=3, mask 8'h03, `en` held high → slots 0,1 each 3 cycles, `frame_start` every 6 cycles, no gap; `ch_in` change mid-frame appears only in the next frame.
- `en` dropped mid-frame (at slot 3, full mask) → slots 4..7 still sent, then IDLE with `a`=0; all-zero mask with `en`=1 → `busy` never asserts.
- Asynchronous reset asserted at slot 5 between clock edges → all outputs 0 immediately; after release with `en`=1, a fresh frame begins at channel 0 with `frame_start`=1.
